// File: rtl/mole_hit_judge_if.sv
// rtl/mole_hit_judge_if.sv - keypad/mole inputs and judge outputs of mole_hit_judge
interface mole_hit_judge_if #(
    parameter int CNT_W = 8
);
    logic             in_game;
    logic [3:0]       key_code;
    logic             key_valid;
    logic [3:0]       mole_pos;
    logic             mole_new;
    logic             hit_pulse;
    logic             miss_pulse;
    logic             mole_hit;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output in_game, key_code, key_valid, mole_pos, mole_new,
        input  hit_pulse, miss_pulse, mole_hit, hit_count, miss_count
    );

    modport slave (
        input  in_game, key_code, key_valid, mole_pos, mole_new,
        output hit_pulse, miss_pulse, mole_hit, hit_count, miss_count
    );
endinterface

// File: rtl/mole_hit_judge.sv
// rtl/mole_hit_judge.sv - debounced one-shot key press judged against mole position
// Optional macro HIT_WRONG_KEY_PENALTY_EN: a wrong-key press on an armed mole counts as a miss.
module mole_hit_judge #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 8
) (
    input  logic           clk,
    input  logic           rst,
    mole_hit_judge_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_MOLE = 2'd1,
        S_ARMED     = 2'd2,
        S_WHACKED   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [3:0]       pos_q, pos_n;
    logic [4:0]       raw, raw_q;
    logic [DB_W-1:0]  db_cnt;
    logic             stable_valid, stable_valid_d;
    logic [3:0]       stable_code;
    logic             press;
    logic             hit_n, miss_n, clr_n;
    logic             hit_pulse_q, miss_pulse_q;
    logic [CNT_W-1:0] hit_count_q, miss_count_q;

    assign raw = {bus.key_valid, bus.key_code};

    // Stable level only moves after the raw sample has held still long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q          <= '0;
            db_cnt         <= '0;
            stable_valid   <= 1'b0;
            stable_code    <= '0;
            stable_valid_d <= 1'b0;
        end else begin
            stable_valid_d <= stable_valid;
            if (raw != raw_q) begin
                raw_q  <= raw;
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable_valid <= raw_q[4];
                stable_code  <= raw_q[3:0];
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = stable_valid & ~stable_valid_d;

    always_comb begin
        state_n = state;
        pos_n   = pos_q;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        clr_n   = 1'b0;
        if (!bus.in_game) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_WAIT_MOLE;
                    clr_n   = 1'b1;
                end
                S_WAIT_MOLE: begin
                    if (bus.mole_new) begin
                        state_n = S_ARMED;
                        pos_n   = bus.mole_pos;
                    end
                end
                S_ARMED: begin
                    // The press is judged against the old position before a new mole lands.
                    if (press && (stable_code == pos_q)) begin
                        hit_n   = 1'b1;
                        state_n = S_WHACKED;
                    end
`ifdef HIT_WRONG_KEY_PENALTY_EN
                    else if (press) begin
                        miss_n = 1'b1;
                    end
`endif
                    if (bus.mole_new) begin
                        state_n = S_ARMED;
                        pos_n   = bus.mole_pos;
                        if (!hit_n) begin
                            miss_n = 1'b1;
                        end
                    end
                end
                S_WHACKED: begin
                    if (bus.mole_new) begin
                        state_n = S_ARMED;
                        pos_n   = bus.mole_pos;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pos_q        <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state        <= state_n;
            pos_q        <= pos_n;
            hit_pulse_q  <= hit_n;
            miss_pulse_q <= miss_n;
            if (clr_n) begin
                hit_count_q  <= '0;
                miss_count_q <= '0;
            end else begin
                if (hit_n && (hit_count_q != CNT_MAX)) begin
                    hit_count_q <= hit_count_q + CNT_W'(1);
                end
                if (miss_n && (miss_count_q != CNT_MAX)) begin
                    miss_count_q <= miss_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.mole_hit   = (state == S_WHACKED);
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_mole_hit_judge.sv
// tb/tb_mole_hit_judge.sv - directed bench with a per-cycle scoreboard model for mole_hit_judge
module tb_mole_hit_judge;
    localparam int D     = 4;
    localparam int CNT_W = 8;
    localparam int HOLD  = D + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mole_hit_judge_if #(.CNT_W(CNT_W)) bus ();

    mole_hit_judge #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model: key age / debounced level, and game view (running, mole up, whacked).
    int         m_age;
    logic [4:0] m_last;
    bit         m_sv, m_sv_prev;
    logic [3:0] m_sc;
    bit         running, mole_up, whacked;
    logic [3:0] target;
    bit         e_hit, e_miss;
    int         e_hc, e_mc;

    always @(posedge clk) begin
        bit press, on_mole, hit, miss;
        if (rst) begin
            m_age = 0; m_last = '0; m_sv = 0; m_sv_prev = 0; m_sc = '0;
            running = 0; mole_up = 0; whacked = 0; target = '0;
            e_hit = 0; e_miss = 0; e_hc = 0; e_mc = 0;
        end else begin
            press  = m_sv && !m_sv_prev;
            e_hit  = 0;
            e_miss = 0;
            if (!bus.in_game) begin
                running = 0; mole_up = 0; whacked = 0;
            end else if (!running) begin
                running = 1; mole_up = 0; whacked = 0; e_hc = 0; e_mc = 0;
            end else begin
                on_mole = mole_up && !whacked;
                hit  = on_mole && press && (m_sc == target);
                miss = 0;
`ifdef HIT_WRONG_KEY_PENALTY_EN
                if (on_mole && press && (m_sc != target)) miss = 1;
`endif
                if (bus.mole_new && on_mole && !hit) miss = 1;
                if (hit) begin
                    e_hit = 1; whacked = 1;
                    if (e_hc < 255) e_hc++;
                end
                if (miss) begin
                    e_miss = 1;
                    if (e_mc < 255) e_mc++;
                end
                if (bus.mole_new) begin
                    mole_up = 1; whacked = 0; target = bus.mole_pos;
                end
            end
            m_sv_prev = m_sv;
            if ({bus.key_valid, bus.key_code} != m_last) begin
                m_last = {bus.key_valid, bus.key_code};
                m_age  = 0;
            end else begin
                if (m_age < D) m_age++;
                if (m_age >= D) begin
                    m_sv = m_last[4];
                    m_sc = m_last[3:0];
                end
            end
        end
    end

    int hit_seen = 0;
    int miss_seen = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("hit_pulse",  32'(bus.hit_pulse),  32'(e_hit));
            check("miss_pulse", 32'(bus.miss_pulse), 32'(e_miss));
            check("mole_hit",   32'(bus.mole_hit),   32'(whacked));
            check("hit_count",  32'(bus.hit_count),  32'(e_hc));
            check("miss_count", 32'(bus.miss_count), 32'(e_mc));
            if (bus.hit_pulse)  hit_seen++;
            if (bus.miss_pulse) miss_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_mole(input logic [3:0] p);
        bus.mole_new = 1'b1;
        bus.mole_pos = p;
        tick(1);
        bus.mole_new = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        tick(HOLD);
        bus.key_valid = 1'b0;
        tick(HOLD);
    endtask

    int hs, ms;

    initial begin
        rst = 1'b1;
        bus.in_game = 1'b0; bus.key_code = '0; bus.key_valid = 1'b0;
        bus.mole_pos = '0; bus.mole_new = 1'b0;
        tick(3);
        chk_en = 1'b1;
        check("rst_hit_count", 32'(bus.hit_count), 0);
        check("rst_miss_count", 32'(bus.miss_count), 0);
        check("rst_pulses", 32'({bus.hit_pulse, bus.miss_pulse, bus.mole_hit}), 0);
        rst = 1'b0;

        // 1: held key produces exactly one hit
        bus.in_game = 1'b1;
        tick(2);
        new_mole(4'd5);
        hs = hit_seen;
        bus.key_valid = 1'b1; bus.key_code = 4'd5;
        tick(D + 1);
        check("t1_no_early_hit", 32'(bus.hit_pulse), 0);
        tick(1);
        check("t1_latency_hit", 32'(bus.hit_pulse), 1);
        tick(20 - D - 2);
        bus.key_valid = 1'b0;
        tick(HOLD);
        check("t1_hit_pulses", 32'(hit_seen - hs), 1);
        check("t1_hit_count", 32'(bus.hit_count), 1);
        check("t1_mole_hit", 32'(bus.mole_hit), 1);

        // 2: bouncing key never debounces
        new_mole(4'd3);
        hs = hit_seen; ms = miss_seen;
        for (int i = 0; i < 6; i++) begin
            bus.key_valid = 1'b1; bus.key_code = 4'd3; tick(2);
            bus.key_valid = 1'b0; tick(2);
        end
        tick(HOLD);
        check("t2_no_hit", 32'(hit_seen - hs), 0);
        check("t2_no_miss", 32'(miss_seen - ms), 0);
        check("t2_hit_count", 32'(bus.hit_count), 1);
        check("t2_mole_hit", 32'(bus.mole_hit), 0);
        press_key(4'd3);
        check("t2_late_hit", 32'(bus.hit_count), 2);

        // 3: escaped mole
        new_mole(4'd7);
        tick(2);
        ms = miss_seen;
        new_mole(4'd2);
        check("t3_miss_pulse", 32'(bus.miss_pulse), 1);
        tick(3);
        check("t3_miss_once", 32'(miss_seen - ms), 1);
        check("t3_miss_count", 32'(bus.miss_count), 1);
        check("t3_mole_hit", 32'(bus.mole_hit), 0);
        press_key(4'd2);
        check("t3_pos_q_2", 32'(bus.hit_count), 3);

        // 4: press coincides with mole_new, judged on old position
        new_mole(4'd9);
        bus.key_valid = 1'b1; bus.key_code = 4'd9;
        tick(D + 1);
        new_mole(4'd1);
        check("t4_hit_pulse", 32'(bus.hit_pulse), 1);
        check("t4_no_miss", 32'(bus.miss_pulse), 0);
        check("t4_mole_hit", 32'(bus.mole_hit), 0);
        tick(3);
        bus.key_valid = 1'b0;
        tick(HOLD);
        check("t4_miss_count", 32'(bus.miss_count), 1);
        press_key(4'd1);
        check("t4_new_pos_hit", 32'(bus.hit_count), 5);

        // 6: wrong key
        new_mole(4'd4);
        ms = miss_seen;
        press_key(4'd6);
`ifdef HIT_WRONG_KEY_PENALTY_EN
        check("t6_wrong_miss", 32'(miss_seen - ms), 1);
        check("t6_miss_count", 32'(bus.miss_count), 2);
`else
        check("t6_wrong_miss", 32'(miss_seen - ms), 0);
        check("t6_miss_count", 32'(bus.miss_count), 1);
`endif
        press_key(4'd4);
        check("t6_hit_count", 32'(bus.hit_count), 6);

        // leaving the game holds counts and clears mole_hit
        bus.in_game = 1'b0;
        tick(2);
        check("idle_mole_hit", 32'(bus.mole_hit), 0);
        check("idle_hit_count", 32'(bus.hit_count), 6);

        // 5: saturation
        bus.in_game = 1'b1;
        tick(2);
        check("restart_clear", 32'(bus.hit_count), 0);
        for (int i = 0; i < 255; i++) begin
            new_mole(4'd0);
            press_key(4'd0);
        end
        check("t5_hit_255", 32'(bus.hit_count), 255);
        hs = hit_seen;
        new_mole(4'd0);
        press_key(4'd0);
        check("t5_sat_pulse", 32'(hit_seen - hs), 1);
        check("t5_sat_count", 32'(bus.hit_count), 255);

        // rst with key held: the key is re-debounced before it can press
        new_mole(4'd5);
        bus.key_valid = 1'b1; bus.key_code = 4'd5;
        rst = 1'b1;
        tick(2);
        check("t5_rst_counts", 32'({bus.hit_count, bus.miss_count}), 0);
        check("t5_rst_outs", 32'({bus.hit_pulse, bus.miss_pulse, bus.mole_hit}), 0);
        rst = 1'b0;
        tick(1);
        new_mole(4'd5);
        tick(HOLD);
        check("t5_post_rst_hit", 32'(bus.hit_count), 1);
        bus.key_valid = 1'b0;
        tick(HOLD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
